// File: rtl/ysyx_22051013_idu_pipe_pkg.sv
// Shared definitions for the pipelined RV64I decode stage: default widths,
// opcode map, ALU-op encoding, load/store and write-back control encodings.
package ysyx_22051013_idu_pipe_pkg;

    localparam int XLEN_DEF = 64;
    localparam int PC_W_DEF = 64;
    localparam int RA_W_DEF = 5;

    // Major opcodes (inst[6:0])
    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_OP32    = 7'b0111011;

    // Instruction class, upper nibble of the 8-bit ALU op
    typedef enum logic [3:0] {
        CLS_NONE    = 4'd0,
        CLS_OP      = 4'd1,
        CLS_OPIMM   = 4'd2,
        CLS_OP32    = 4'd3,
        CLS_OPIMM32 = 4'd4,
        CLS_LUI     = 4'd5,
        CLS_AUIPC   = 4'd6,
        CLS_JAL     = 4'd7,
        CLS_JALR    = 4'd8,
        CLS_BRANCH  = 4'd9,
        CLS_LOAD    = 4'd10,
        CLS_STORE   = 4'd11
    } op_cls_e;

    // ALU op = {class, funct3, alternate (SUB/SRA) bit}
    localparam logic [7:0] INST_AUIPC = {4'(CLS_AUIPC), 4'b0000};
    localparam logic [7:0] INST_JAL   = {4'(CLS_JAL),   4'b0000};

    // lsctl: 1uss = load (u = unsigned, ss = size), 01ss = store, 0000 = none
    localparam logic [3:0] LS_NONE = 4'b0000;

    // wbctl: write-back source select
    localparam logic [1:0] WB_NONE = 2'b00;
    localparam logic [1:0] WB_ALU  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_PC4  = 2'b11;

    function automatic logic [7:0] mk_aluop(input op_cls_e cls, input logic [2:0] f3,
                                            input logic alt);
        return {4'(cls), f3, alt};
    endfunction

    function automatic logic is_load(input logic [3:0] lsctl);
        return lsctl[3];
    endfunction

endpackage

// File: rtl/ysyx_22051013_idu_pipe_if.sv
// Bus bundle around the decode stage: IFU handshake, regfile read port,
// EX/MEM bypass inputs, redirect, and the ID/EX register towards the EXU.
interface ysyx_22051013_idu_pipe_if
    import ysyx_22051013_idu_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int PC_W = PC_W_DEF,
    parameter int RA_W = RA_W_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst_i;
    logic [PC_W-1:0] pc_i;
    logic [RA_W-1:0] rs1_addr;
    logic [RA_W-1:0] rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            mem_rd_ena;
    logic [RA_W-1:0] mem_rd_addr;
    logic [XLEN-1:0] mem_rd_data;
    logic [XLEN-1:0] ex_result_i;
    logic            flush_i;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] imm;
    logic [PC_W-1:0] pc_o;
    logic            rd_ena;
    logic [RA_W-1:0] rd_addr;
    logic [7:0]      alusrc_o;
    logic [3:0]      lsctl_o;
    logic [1:0]      wbctl_o;
    logic            branch_o;
    logic            jump_o;

    // Decode stage side
    modport slave (
        input  in_valid, inst_i, pc_i, rs1_data, rs2_data,
               mem_rd_ena, mem_rd_addr, mem_rd_data, ex_result_i,
               flush_i, out_ready,
        output in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, imm, pc_o,
               rd_ena, rd_addr, alusrc_o, lsctl_o, wbctl_o, branch_o, jump_o
    );

    // Surrounding pipeline (IFU, regfile, EXU, MEM) side
    modport master (
        output in_valid, inst_i, pc_i, rs1_data, rs2_data,
               mem_rd_ena, mem_rd_addr, mem_rd_data, ex_result_i,
               flush_i, out_ready,
        input  in_ready, rs1_addr, rs2_addr, out_valid, op1, op2, imm, pc_o,
               rd_ena, rd_addr, alusrc_o, lsctl_o, wbctl_o, branch_o, jump_o
    );

endinterface

// File: rtl/ysyx_22051013_idu_decode.sv
// Combinational RV64I instruction decoder: source/immediate usage, extended
// immediate, jump/branch flags and ALU / load-store / write-back control.
module ysyx_22051013_idu_decode
    import ysyx_22051013_idu_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [31:0]     i_inst,
    output logic            o_rs1_ena,
    output logic            o_rs2_ena,
    output logic            o_imm_ena,
    output logic [XLEN-1:0] o_imm,
    output logic            o_jump,
    output logic            o_branch,
    output logic [7:0]      o_alusrc,
    output logic [3:0]      o_lsctl,
    output logic [1:0]      o_wbctl,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd
);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;
    logic [XLEN-1:0] w_imm_u;
    logic [XLEN-1:0] w_imm_j;

    assign w_opc = i_inst[6:0];
    assign w_f3  = i_inst[14:12];
    assign o_rs1 = i_inst[19:15];
    assign o_rs2 = i_inst[24:20];
    assign o_rd  = i_inst[11:7];

    assign w_imm_i = {{(XLEN-12){i_inst[31]}}, i_inst[31:20]};
    assign w_imm_s = {{(XLEN-12){i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
    assign w_imm_b = {{(XLEN-13){i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                      i_inst[11:8], 1'b0};
    assign w_imm_u = {{(XLEN-32){i_inst[31]}}, i_inst[31:12], 12'b0};
    assign w_imm_j = {{(XLEN-21){i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                      i_inst[30:21], 1'b0};

    // Per-opcode selection of operand usage, immediate format and control buses
    always_comb begin
        o_rs1_ena = 1'b0;
        o_rs2_ena = 1'b0;
        o_imm_ena = 1'b0;
        o_imm     = '0;
        o_jump    = 1'b0;
        o_branch  = 1'b0;
        o_alusrc  = '0;
        o_lsctl   = LS_NONE;
        o_wbctl   = WB_NONE;
        case (w_opc)
            OPC_LUI: begin
                o_imm_ena = 1'b1;
                o_imm     = w_imm_u;
                o_alusrc  = mk_aluop(CLS_LUI, 3'b000, 1'b0);
                o_wbctl   = WB_ALU;
            end
            OPC_AUIPC: begin
                o_imm_ena = 1'b1;
                o_imm     = w_imm_u;
                o_alusrc  = mk_aluop(CLS_AUIPC, 3'b000, 1'b0);
                o_wbctl   = WB_ALU;
            end
            OPC_JAL: begin
                o_imm_ena = 1'b1;
                o_imm     = w_imm_j;
                o_jump    = 1'b1;
                o_alusrc  = mk_aluop(CLS_JAL, 3'b000, 1'b0);
                o_wbctl   = WB_PC4;
            end
            OPC_JALR: begin
                o_rs1_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_i;
                o_jump    = 1'b1;
                o_alusrc  = mk_aluop(CLS_JALR, 3'b000, 1'b0);
                o_wbctl   = WB_PC4;
            end
            OPC_BRANCH: begin
                o_rs1_ena = 1'b1;
                o_rs2_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_b;
                o_branch  = 1'b1;
                o_alusrc  = mk_aluop(CLS_BRANCH, w_f3, 1'b0);
            end
            OPC_LOAD: begin
                o_rs1_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_i;
                o_alusrc  = mk_aluop(CLS_LOAD, w_f3, 1'b0);
                o_lsctl   = {1'b1, w_f3};
                o_wbctl   = WB_MEM;
            end
            OPC_STORE: begin
                o_rs1_ena = 1'b1;
                o_rs2_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_s;
                o_alusrc  = mk_aluop(CLS_STORE, w_f3, 1'b0);
                o_lsctl   = {2'b01, w_f3[1:0]};
            end
            OPC_OPIMM: begin
                o_rs1_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_i;
                o_alusrc  = mk_aluop(CLS_OPIMM, w_f3, (w_f3 == 3'b101) & i_inst[30]);
                o_wbctl   = WB_ALU;
            end
            OPC_OPIMM32: begin
                o_rs1_ena = 1'b1;
                o_imm_ena = 1'b1;
                o_imm     = w_imm_i;
                o_alusrc  = mk_aluop(CLS_OPIMM32, w_f3, (w_f3 == 3'b101) & i_inst[30]);
                o_wbctl   = WB_ALU;
            end
            OPC_OP: begin
                o_rs1_ena = 1'b1;
                o_rs2_ena = 1'b1;
                o_alusrc  = mk_aluop(CLS_OP, w_f3, i_inst[30]);
                o_wbctl   = WB_ALU;
            end
            OPC_OP32: begin
                o_rs1_ena = 1'b1;
                o_rs2_ena = 1'b1;
                o_alusrc  = mk_aluop(CLS_OP32, w_f3, i_inst[30]);
                o_wbctl   = WB_ALU;
            end
            default: begin
                o_rs1_ena = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_idu_pipe.sv
// Pipelined RV64I decode stage with ID/EX register, RAW interlock and redirect
// flush. Optional EX/MEM operand forwarding is enabled by defining the macro
// YSYX_22051013_IDU_FWD_EN; without it the stage fully interlocks.
module ysyx_22051013_idu_pipe
    import ysyx_22051013_idu_pipe_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int PC_W = PC_W_DEF,
    parameter int RA_W = RA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    ysyx_22051013_idu_pipe_if.slave   bus
);

    // Decoder outputs
    logic            w_rs1_ena;
    logic            w_rs2_ena;
    logic            w_imm_ena;
    logic [XLEN-1:0] w_imm;
    logic            w_jump;
    logic            w_branch;
    logic [7:0]      w_alusrc;
    logic [3:0]      w_lsctl;
    logic [1:0]      w_wbctl;
    logic [4:0]      w_dec_rs1;
    logic [4:0]      w_dec_rs2;
    logic [4:0]      w_dec_rd;

    // Hazard / operand selection
    logic [RA_W-1:0] w_rs1_addr;
    logic [RA_W-1:0] w_rs2_addr;
    logic            w_rd_ena;
    logic            w_held1;
    logic            w_held2;
    logic            w_mem1;
    logic            w_mem2;
    logic            w_hz1;
    logic            w_hz2;
    logic            w_hazard;
    logic            w_in_ready;
    logic            w_fire;
    logic [XLEN-1:0] w_src1;
    logic [XLEN-1:0] w_src2;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // ID/EX register
    logic            r_valid;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_imm;
    logic [PC_W-1:0] r_pc;
    logic            r_rd_ena;
    logic [RA_W-1:0] r_rd_addr;
    logic [7:0]      r_alusrc;
    logic [3:0]      r_lsctl;
    logic [1:0]      r_wbctl;
    logic            r_branch;
    logic            r_jump;

    ysyx_22051013_idu_decode #(
        .XLEN (XLEN)
    ) u_decode (
        .i_inst    (bus.inst_i),
        .o_rs1_ena (w_rs1_ena),
        .o_rs2_ena (w_rs2_ena),
        .o_imm_ena (w_imm_ena),
        .o_imm     (w_imm),
        .o_jump    (w_jump),
        .o_branch  (w_branch),
        .o_alusrc  (w_alusrc),
        .o_lsctl   (w_lsctl),
        .o_wbctl   (w_wbctl),
        .o_rs1     (w_dec_rs1),
        .o_rs2     (w_dec_rs2),
        .o_rd      (w_dec_rd)
    );

    // Unused sources read as x0, so they can never match a destination
    assign w_rs1_addr = w_rs1_ena ? RA_W'(w_dec_rs1) : '0;
    assign w_rs2_addr = w_rs2_ena ? RA_W'(w_dec_rs2) : '0;
    assign w_rd_ena   = (w_dec_rd != 5'd0) && (w_wbctl != WB_NONE);

    // Destination matches against the held instruction and the EX/MEM one
    assign w_held1 = (w_rs1_addr != '0) & r_valid & r_rd_ena & (r_rd_addr == w_rs1_addr);
    assign w_held2 = (w_rs2_addr != '0) & r_valid & r_rd_ena & (r_rd_addr == w_rs2_addr);
    assign w_mem1  = (w_rs1_addr != '0) & bus.mem_rd_ena & (bus.mem_rd_addr == w_rs1_addr);
    assign w_mem2  = (w_rs2_addr != '0) & bus.mem_rd_ena & (bus.mem_rd_addr == w_rs2_addr);

`ifdef YSYX_22051013_IDU_FWD_EN
    // Only a load still in EXU cannot be bypassed; everything else is forwarded
    assign w_hz1  = w_held1 & is_load(r_lsctl);
    assign w_hz2  = w_held2 & is_load(r_lsctl);
    assign w_src1 = w_held1 ? bus.ex_result_i : (w_mem1 ? bus.mem_rd_data : bus.rs1_data);
    assign w_src2 = w_held2 ? bus.ex_result_i : (w_mem2 ? bus.mem_rd_data : bus.rs2_data);
`else
    // Full interlock: wait until the producer has left EX/MEM and written back
    logic w_unused_fwd;
    assign w_unused_fwd = ^{bus.ex_result_i, bus.mem_rd_data};
    assign w_hz1  = w_held1 | w_mem1;
    assign w_hz2  = w_held2 | w_mem2;
    assign w_src1 = bus.rs1_data;
    assign w_src2 = bus.rs2_data;
`endif

    assign w_hazard   = bus.in_valid & (w_hz1 | w_hz2);
    assign w_in_ready = ~w_hazard & (~r_valid | bus.out_ready);
    assign w_fire     = bus.in_valid & w_in_ready;

    assign w_op1 = w_rs1_ena ? w_src1 :
                   ((w_alusrc == INST_AUIPC) || (w_alusrc == INST_JAL)) ? XLEN'(bus.pc_i) :
                   '0;
    assign w_op2 = w_rs2_ena ? w_src2 : (w_imm_ena ? w_imm : '0);

    // ID/EX valid: flush beats a new accept, which beats a drain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= 1'b0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
        end else if (w_fire) begin
            r_valid <= 1'b1;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    // ID/EX payload: loaded only on an accepted, non-flushed instruction
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_imm     <= '0;
            r_pc      <= '0;
            r_rd_ena  <= 1'b0;
            r_rd_addr <= '0;
            r_alusrc  <= '0;
            r_lsctl   <= LS_NONE;
            r_wbctl   <= WB_NONE;
            r_branch  <= 1'b0;
            r_jump    <= 1'b0;
        end else if (w_fire && !bus.flush_i) begin
            r_op1     <= w_op1;
            r_op2     <= w_op2;
            r_imm     <= w_imm;
            r_pc      <= bus.pc_i;
            r_rd_ena  <= w_rd_ena;
            r_rd_addr <= RA_W'(w_dec_rd);
            r_alusrc  <= w_alusrc;
            r_lsctl   <= w_lsctl;
            r_wbctl   <= w_wbctl;
            r_branch  <= w_branch;
            r_jump    <= w_jump;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.rs1_addr  = w_rs1_addr;
    assign bus.rs2_addr  = w_rs2_addr;
    assign bus.out_valid = r_valid;
    assign bus.op1       = r_op1;
    assign bus.op2       = r_op2;
    assign bus.imm       = r_imm;
    assign bus.pc_o      = r_pc;
    assign bus.rd_ena    = r_rd_ena;
    assign bus.rd_addr   = r_rd_addr;
    assign bus.alusrc_o  = r_alusrc;
    assign bus.lsctl_o   = r_lsctl;
    assign bus.wbctl_o   = r_wbctl;
    assign bus.branch_o  = r_branch;
    assign bus.jump_o    = r_jump;

endmodule

// File: tb/tb_ysyx_22051013_idu_pipe.sv
// Directed bench for the pipelined decode stage. The surrounding pipeline
// (regfile, EX/MEM bypass bus, EXU handshake) is driven by hand per scenario.
module tb_ysyx_22051013_idu_pipe;

    logic        clk;
    logic        rst;
    int          n_chk;
    int          n_err;
    logic [63:0] rf [32];

    localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093;
    localparam logic [31:0] I_ADD_X2_X1   = 32'h00108133;
    localparam logic [31:0] I_LD_X3_X4    = 32'h00023183;
    localparam logic [31:0] I_ADD_X5_X3   = 32'h000182B3;
    localparam logic [31:0] I_AUIPC_X6_1  = 32'h00001317;
    localparam logic [31:0] I_ADDI_X7_3   = 32'h00300393;
    localparam logic [31:0] I_SD_X5_8_X6  = 32'h00533423;
    localparam logic [31:0] I_ADDI_X0_1   = 32'h00100013;
    localparam logic [31:0] I_ADD_X3_X0   = 32'h000001B3;
    localparam logic [31:0] I_ADDI_X9_M1  = 32'hFFF00493;
    localparam logic [31:0] I_JAL_X1_16   = 32'h010000EF;

    ysyx_22051013_idu_pipe_if #(.XLEN(64), .PC_W(64), .RA_W(5)) ifc ();

    ysyx_22051013_idu_pipe #(.XLEN(64), .PC_W(64), .RA_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifc)
    );

    assign ifc.rs1_data = rf[ifc.rs1_addr];
    assign ifc.rs2_data = rf[ifc.rs2_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        ifc.in_valid    = 1'b0;
        ifc.inst_i      = 32'h00000013;
        ifc.pc_i        = '0;
        ifc.mem_rd_ena  = 1'b0;
        ifc.mem_rd_addr = '0;
        ifc.mem_rd_data = '0;
        ifc.ex_result_i = '0;
        ifc.flush_i     = 1'b0;
        ifc.out_ready   = 1'b1;
    endtask

    task automatic drain();
        drive_idle();
        tick();
        tick();
    endtask

    task automatic test_reset();
        #1;
        n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %0h want 0", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h0) begin n_err++; $display("FAIL reset_op1: got %0h want 0", ifc.op1); end
        n_chk++; if (ifc.pc_o !== 64'h0) begin n_err++; $display("FAIL reset_pc_o: got %0h want 0", ifc.pc_o); end
        n_chk++; if (ifc.rd_ena !== 1'b0) begin n_err++; $display("FAIL reset_rd_ena: got %0h want 0", ifc.rd_ena); end
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %0h want 1", ifc.in_ready); end
    endtask

    task automatic test_addi();
        drain();
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_ADDI_X1_5;
        ifc.pc_i     = 64'h80000000;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL addi_in_ready: got %0h want 1", ifc.in_ready); end
        n_chk++; if (ifc.rs2_addr !== 5'd0) begin n_err++; $display("FAIL addi_rs2_addr: got %0d want 0", ifc.rs2_addr); end
        tick();
        ifc.in_valid = 1'b0;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL addi_out_valid: got %0h want 1", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h0) begin n_err++; $display("FAIL addi_op1: got %0h want 0", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h5) begin n_err++; $display("FAIL addi_op2: got %0h want 5", ifc.op2); end
        n_chk++; if (ifc.rd_addr !== 5'd1) begin n_err++; $display("FAIL addi_rd_addr: got %0d want 1", ifc.rd_addr); end
        n_chk++; if (ifc.rd_ena !== 1'b1) begin n_err++; $display("FAIL addi_rd_ena: got %0h want 1", ifc.rd_ena); end
        n_chk++; if (ifc.pc_o !== 64'h80000000) begin n_err++; $display("FAIL addi_pc_o: got %0h want 80000000", ifc.pc_o); end
        n_chk++; if (ifc.wbctl_o !== 2'b01) begin n_err++; $display("FAIL addi_wbctl: got %0h want 1", ifc.wbctl_o); end
    endtask

    task automatic test_back_to_back();
        drain();
        rf[1] = 64'h77;
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_ADDI_X1_5;
        ifc.pc_i     = 64'h80000000;
        tick();
        ifc.inst_i = I_ADD_X2_X1;
        ifc.pc_i   = 64'h80000004;
`ifdef YSYX_22051013_IDU_FWD_EN
        ifc.ex_result_i = 64'h5;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL fwd_b2b_in_ready: got %0h want 1", ifc.in_ready); end
        tick();
        ifc.in_valid    = 1'b0;
        ifc.ex_result_i = '0;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL fwd_b2b_out_valid: got %0h want 1", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h5) begin n_err++; $display("FAIL fwd_b2b_op1: got %0h want 5", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h5) begin n_err++; $display("FAIL fwd_b2b_op2: got %0h want 5", ifc.op2); end
        // load-use: exactly one bubble, then bypass from MEM
        drain();
        rf[3] = 64'h33;
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_LD_X3_X4;
        tick();
        ifc.inst_i      = I_ADD_X5_X3;
        ifc.ex_result_i = 64'hBAD;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL lduse_bubble: got %0h want 0", ifc.in_ready); end
        tick();
        ifc.ex_result_i = '0;
        ifc.mem_rd_ena  = 1'b1;
        ifc.mem_rd_addr = 5'd3;
        ifc.mem_rd_data = 64'hDEAD;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL lduse_resume: got %0h want 1", ifc.in_ready); end
        tick();
        drive_idle();
        #1;
        n_chk++; if (ifc.op1 !== 64'hDEAD) begin n_err++; $display("FAIL lduse_op1: got %0h want dead", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h0) begin n_err++; $display("FAIL lduse_op2: got %0h want 0", ifc.op2); end
`else
        #1;
        n_chk++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_held: got %0h want 0", ifc.in_ready); end
        n_chk++; if (ifc.rs1_addr !== 5'd1) begin n_err++; $display("FAIL b2b_rs1_addr: got %0d want 1", ifc.rs1_addr); end
        n_chk++; if (ifc.rs2_addr !== 5'd1) begin n_err++; $display("FAIL b2b_rs2_addr: got %0d want 1", ifc.rs2_addr); end
        tick();
        ifc.mem_rd_ena  = 1'b1;
        ifc.mem_rd_addr = 5'd1;
        ifc.mem_rd_data = 64'h5;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drained: got %0h want 0", ifc.out_valid); end
        n_chk++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL b2b_stall_mem: got %0h want 0", ifc.in_ready); end
        tick();
        ifc.mem_rd_ena = 1'b0;
        rf[1] = 64'h5;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_resume: got %0h want 1", ifc.in_ready); end
        tick();
        ifc.in_valid = 1'b0;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_out_valid: got %0h want 1", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h5) begin n_err++; $display("FAIL b2b_op1: got %0h want 5", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h5) begin n_err++; $display("FAIL b2b_op2: got %0h want 5", ifc.op2); end
        n_chk++; if (ifc.pc_o !== 64'h80000004) begin n_err++; $display("FAIL b2b_pc_o: got %0h want 80000004", ifc.pc_o); end
`endif
    endtask

    task automatic test_store_imm_jal();
        drain();
        rf[5] = 64'h55;
        rf[6] = 64'h6000;
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_SD_X5_8_X6;
        tick();
        ifc.inst_i = I_ADDI_X9_M1;
        #1;
        n_chk++; if (ifc.op1 !== 64'h6000) begin n_err++; $display("FAIL sd_op1: got %0h want 6000", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h55) begin n_err++; $display("FAIL sd_op2: got %0h want 55", ifc.op2); end
        n_chk++; if (ifc.imm !== 64'h8) begin n_err++; $display("FAIL sd_imm: got %0h want 8", ifc.imm); end
        n_chk++; if (ifc.rd_ena !== 1'b0) begin n_err++; $display("FAIL sd_rd_ena: got %0h want 0", ifc.rd_ena); end
        n_chk++; if (ifc.lsctl_o !== 4'b0111) begin n_err++; $display("FAIL sd_lsctl: got %0h want 7", ifc.lsctl_o); end
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL thru_in_ready: got %0h want 1", ifc.in_ready); end
        tick();
        ifc.inst_i = I_JAL_X1_16;
        ifc.pc_i   = 64'h200;
        #1;
        n_chk++; if (ifc.op2 !== 64'hFFFFFFFFFFFFFFFF) begin n_err++; $display("FAIL negimm_op2: got %0h want all ones", ifc.op2); end
        tick();
        ifc.in_valid = 1'b0;
        #1;
        n_chk++; if (ifc.op1 !== 64'h200) begin n_err++; $display("FAIL jal_op1: got %0h want 200", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h10) begin n_err++; $display("FAIL jal_op2: got %0h want 10", ifc.op2); end
        n_chk++; if (ifc.jump_o !== 1'b1) begin n_err++; $display("FAIL jal_jump: got %0h want 1", ifc.jump_o); end
        n_chk++; if (ifc.wbctl_o !== 2'b11) begin n_err++; $display("FAIL jal_wbctl: got %0h want 3", ifc.wbctl_o); end
    endtask

    task automatic test_x0();
        drain();
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_ADDI_X0_1;
        tick();
        ifc.inst_i      = I_ADD_X3_X0;
        ifc.mem_rd_ena  = 1'b1;
        ifc.mem_rd_addr = 5'd0;
        #1;
        n_chk++; if (ifc.rd_ena !== 1'b0) begin n_err++; $display("FAIL x0_rd_ena: got %0h want 0", ifc.rd_ena); end
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL x0_no_hazard: got %0h want 1", ifc.in_ready); end
    endtask

    task automatic test_stall_flush();
        drain();
        rf[4] = 64'h4000;
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_LD_X3_X4;
        ifc.pc_i     = 64'h300;
        tick();
        ifc.out_ready = 1'b0;
        ifc.inst_i    = I_ADDI_X7_3;
        ifc.pc_i      = 64'h304;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_chk++; if (ifc.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready[%0d]: got %0h want 0", k, ifc.in_ready); end
            n_chk++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL stall_out_valid[%0d]: got %0h want 1", k, ifc.out_valid); end
            n_chk++; if (ifc.op1 !== 64'h4000) begin n_err++; $display("FAIL stall_op1[%0d]: got %0h want 4000", k, ifc.op1); end
            n_chk++; if (ifc.pc_o !== 64'h300) begin n_err++; $display("FAIL stall_pc_o[%0d]: got %0h want 300", k, ifc.pc_o); end
            n_chk++; if (ifc.lsctl_o !== 4'b1011) begin n_err++; $display("FAIL stall_lsctl[%0d]: got %0h want b", k, ifc.lsctl_o); end
            tick();
        end
        ifc.flush_i   = 1'b1;
        ifc.out_ready = 1'b1;
        #1;
        n_chk++; if (ifc.in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %0h want 1", ifc.in_ready); end
        tick();
        drive_idle();
        #1;
        n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_drop: got %0h want 0", ifc.out_valid); end
        n_chk++; if (ifc.pc_o !== 64'h300) begin n_err++; $display("FAIL flush_no_load: got %0h want 300", ifc.pc_o); end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        ifc.in_valid = 1'b1;
        ifc.inst_i   = I_LD_X3_X4;
        ifc.pc_i     = 64'h400;
        tick();
        ifc.in_valid  = 1'b0;
        ifc.out_ready = 1'b0;
        tick();
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_mid_out_valid: got %0h want 0", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h0) begin n_err++; $display("FAIL rst_mid_op1: got %0h want 0", ifc.op1); end
        n_chk++; if (ifc.pc_o !== 64'h0) begin n_err++; $display("FAIL rst_mid_pc_o: got %0h want 0", ifc.pc_o); end
        n_chk++; if (ifc.lsctl_o !== 4'b0000) begin n_err++; $display("FAIL rst_mid_lsctl: got %0h want 0", ifc.lsctl_o); end
        n_chk++; if (ifc.rd_addr !== 5'd0) begin n_err++; $display("FAIL rst_mid_rd_addr: got %0d want 0", ifc.rd_addr); end
        tick();
        rst = 1'b1;
        ifc.out_ready = 1'b1;
        ifc.in_valid  = 1'b1;
        ifc.inst_i    = I_AUIPC_X6_1;
        ifc.pc_i      = 64'h100;
        #1;
        n_chk++; if (ifc.rs1_addr !== 5'd0) begin n_err++; $display("FAIL auipc_rs1_addr: got %0d want 0", ifc.rs1_addr); end
        tick();
        ifc.in_valid = 1'b0;
        #1;
        n_chk++; if (ifc.out_valid !== 1'b1) begin n_err++; $display("FAIL auipc_out_valid: got %0h want 1", ifc.out_valid); end
        n_chk++; if (ifc.op1 !== 64'h100) begin n_err++; $display("FAIL auipc_op1: got %0h want 100", ifc.op1); end
        n_chk++; if (ifc.op2 !== 64'h1000) begin n_err++; $display("FAIL auipc_op2: got %0h want 1000", ifc.op2); end
        n_chk++; if (ifc.rd_addr !== 5'd6) begin n_err++; $display("FAIL auipc_rd_addr: got %0d want 6", ifc.rd_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 32; i++) rf[i] = 64'h1000 + 64'(i);
        rf[0] = 64'h0;
        rst = 1'b0;
        drive_idle();
        tick();
        tick();
        test_reset();
        rst = 1'b1;
        tick();
        test_addi();
        test_back_to_back();
        test_store_imm_jal();
        test_x0();
        test_stall_flush();
        test_reset_mid_stall();
        drain();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
